// File: rtl/led_ctrl_pkg.sv
// Shared opcodes, FSM state type and sizing helpers
// for the UART-driven LED PWM controller.
package led_ctrl_pkg;

  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_r = 8'h72;
  localparam logic [7:0] CMD_g = 8'h67;
  localparam logic [7:0] CMD_b = 8'h62;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_X = 8'h58;

  localparam int CH_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_CH,
    ST_GET_DUTY
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/led_pwm_controller_pwm_channel.sv
// One PWM channel: shadow duty, period-aligned active
// duty and a registered compare output.
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic                commit,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                led
);

  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic                led_q, led_d;

  // a write landing on the commit cycle is committed directly
  always_comb begin
    shadow_d = wr_en ? wr_duty : shadow_q;
    active_d = commit ? shadow_d : active_q;
    led_d    = (active_q == '1) | (cnt < active_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pwm_controller.sv
// Command decoder, timeout, prescaler and shared PWM
// counter driving N_CH pwm_channel instances.
module led_pwm_controller
  import led_ctrl_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_byte,
  input  logic            rx_done,
  output logic [N_CH-1:0] led,
  output logic            busy,
  output logic            cmd_ok,
  output logic            cmd_err
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TO_W = cnt_w(TIMEOUT_CYC);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0] NCH5 = 5'(N_CH);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                tick, commit;

  logic                lt_vld, lt_on;
  logic [CH_W-1:0]     lt_ch;
  logic                wr_all, wr_one;
  logic [CH_W-1:0]     wr_sel;
  logic [PWM_BITS-1:0] wr_val;
  logic [N_CH-1:0]     wr_en;

  always_comb begin
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
    commit  = tick && (cnt_q == '1);
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    to_d    = to_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    lt_vld  = 1'b0;
    lt_on   = 1'b0;
    lt_ch   = '0;
    wr_all  = 1'b0;
    wr_one  = 1'b0;
    wr_sel  = '0;
    wr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        to_d = '0;
        if (rx_done) begin
          case (rx_byte)
            CMD_R: begin lt_vld = 1'b1; lt_on = 1'b1; lt_ch = 4'd0; end
            CMD_G: begin lt_vld = 1'b1; lt_on = 1'b1; lt_ch = 4'd1; end
            CMD_B: begin lt_vld = 1'b1; lt_on = 1'b1; lt_ch = 4'd2; end
            CMD_r: begin lt_vld = 1'b1; lt_ch = 4'd0; end
            CMD_g: begin lt_vld = 1'b1; lt_ch = 4'd1; end
            CMD_b: begin lt_vld = 1'b1; lt_ch = 4'd2; end
            CMD_X: begin wr_all = 1'b1; ok_d = 1'b1; end
            CMD_D: state_d = ST_GET_CH;
            default: err_d = 1'b1;
          endcase
          if (lt_vld) begin
            if ({1'b0, lt_ch} < NCH5) begin
              wr_one = 1'b1;
              wr_sel = lt_ch;
              wr_val = lt_on ? '1 : '0;
              ok_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_GET_CH: begin
        if (rx_done) begin
          to_d = '0;
          if (rx_byte < 8'(N_CH)) begin
            ch_d    = rx_byte[CH_W-1:0];
            state_d = ST_GET_DUTY;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (to_q == TO_LAST) begin
          to_d    = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_GET_DUTY: begin
        if (rx_done) begin
          to_d    = '0;
          wr_one  = 1'b1;
          wr_sel  = ch_q;
          wr_val  = rx_byte[7 -: PWM_BITS];
          ok_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (to_q == TO_LAST) begin
          to_d    = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < N_CH; i++) begin
      wr_en[i] = wr_all | (wr_one && (wr_sel == 4'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      to_q    <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      to_q    <= to_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en[g]),
      .wr_duty(wr_val),
      .commit (commit),
      .cnt    (cnt_q),
      .led    (led[g])
    );
  end

  assign busy    = (state_q != ST_IDLE);
  assign cmd_ok  = ok_q;
  assign cmd_err = err_q;

endmodule

// File: doc/led_pwm_controller.md
Name: led_pwm_controller

Overview:
- Parametrised successor to the fixed on/off RGB LED controller.
- Decodes bytes from the UART receiver (`rx_byte` / `rx_done`) into per-channel brightness commands and drives N_CH LEDs with glitch-free PWM.
- Keeps the single-byte R/G/B on/off commands.
- Adds a multi-byte duty command, an all-off command, error and timeout reporting, and shadowed duty updates applied only at PWM period boundaries.

Parameters:
- N_CH, 3, number of LED channels (1..16); channels 0/1/2 are R/G/B.
- PWM_BITS, 8, PWM resolution (1..8); period = 2^PWM_BITS ticks.
- PRESCALE, 1, clk cycles per PWM tick (>=1).
- TIMEOUT_CYC, 100000, max clk cycles between bytes of a multi-byte command.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_byte  in  8  received byte; valid only while rx_done=1.
- rx_done  in  1  one-cycle strobe from the UART receiver.
- led  out  N_CH  PWM outputs; led[0]=R, led[1]=G, led[2]=B.
- busy  out  1  high while a multi-byte command is in progress.
- cmd_ok  out  1  one-cycle pulse when a command is accepted.
- cmd_err  out  1  one-cycle pulse on an invalid byte, invalid channel, or timeout.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values: `led`=0, `busy`=0, `cmd_ok`=0, `cmd_err`=0. All shadow and active duty registers = 0, PWM counter = 0, prescaler = 0, FSM state IDLE.
- Reset mid-command: `rst` in any state returns to IDLE on the next edge and clears all duties; the partially received command is discarded.
- Command FSM states: IDLE, GET_CH, GET_DUTY. Bytes are consumed only on cycles with `rx_done`=1.
- IDLE, single-byte commands:
  - 'R'/'G'/'B' (0x52/0x47/0x42): shadow duty of ch 0/1/2 = all-ones (full on).
  - 'r'/'g'/'b' (0x72/0x67/0x62): shadow duty of that channel = 0.
  - A letter whose channel index is >= N_CH produces `cmd_err`.
  - 'X' (0x58): all shadow duties = 0.
  - Each accepted single-byte command pulses `cmd_ok` on the cycle after `rx_done`.
- IDLE, 'D' (0x44): go to GET_CH and assert `busy`. No pulse.
- GET_CH: byte is the binary channel index.
  - Index < N_CH: latch it, go to GET_DUTY.
  - Otherwise: pulse `cmd_err`, go to IDLE.
- GET_DUTY: shadow duty[ch] = rx_byte[7:8-PWM_BITS] (upper bits). Pulse `cmd_ok`, go to IDLE.
- Any other byte in IDLE: pulse `cmd_err`, no state change.
- Timeout:
  - The counter clears on entry to GET_CH/GET_DUTY and on each consumed byte.
  - When it reaches TIMEOUT_CYC with no byte, pulse `cmd_err` and go to IDLE.
  - If a byte arrives on the timeout cycle, the byte wins.
- `busy` = (state != IDLE), registered.
- PWM timing:
  - Prescaler counts 0..PRESCALE-1; the PWM counter increments when the prescaler wraps.
  - The PWM counter is free-running, PWM_BITS wide, and wraps from all-ones to 0.
- Duty commit:
  - On the tick where the PWM counter wraps to 0, active duty[i] <= shadow duty[i] for all i.
  - If a shadow write happens on the same cycle as the commit, the new value is committed.
- Output: led[i] registered = (active==all-ones) | (cnt < active). Duty 0 gives constant 0; all-ones gives constant 1.
- Latency: command byte -> shadow update takes 1 cycle. Shadow -> `led` takes at most 2^PWM_BITS*PRESCALE + 1 cycles.

Decomposition:
- Package `led_ctrl_pkg`:
  - ASCII opcode constants: CMD_R, CMD_G, CMD_B, CMD_r, CMD_g, CMD_b, CMD_D, CMD_X.
  - FSM state enum.
  - Timeout-counter width function (clog2).
- Sub-module `pwm_channel`, instantiated N_CH times:
  - Contains the shadow and active duty registers and the compare logic.
  - Takes `clk`, `rst`, `wr_en`, `wr_duty`, `commit`, `cnt`.
  - Drives one `led` bit.
- The top level holds the FSM, the timeout counter, the prescaler and the shared PWM counter.

Test Plan:
All scenarios use N_CH=3, PWM_BITS=4, PRESCALE=1, TIMEOUT_CYC=64, giving a 16-cycle period.
1. Reset, then send 'R' -> `cmd_ok` pulses once; within 17 cycles led[0]=1 constant; led[1]=led[2]=0.
2. Send 'D',0x01,0x80 -> `busy`=1 between bytes; `cmd_ok` after the third byte; after the next wrap led[1] is high 8 / low 8 cycles every period.
3. With led[1] at 50%, send 'D',0x01,0x20 mid-period -> current period completes at 8/16; next period is 2/16, with no runt pulse.
4. Send 'D',0x05 -> `cmd_err` pulse, `busy`=0, no duty changes. Send 'Q' in IDLE -> `cmd_err`, no change.
5. Send 'D' then nothing -> `cmd_err` pulses exactly 64 cycles later and `busy` falls. A following 'B' is accepted normally (led[2]=1 after wrap).
6. Set all channels on, send 'X' -> all `led`=0 after the next wrap. Assert `rst` during GET_DUTY -> next cycle `busy`=0 and `led`=0; a later duty byte alone yields `cmd_err`.
